// File: rtl/sort_merge_pkg.sv
// Shared constants and types for the 4-lane sort/merge sequencing controller.
package sort_merge_pkg;

  localparam int NLANES       = 4;
  localparam int LANE_SELW    = $clog2(NLANES);
  localparam int DEF_SORT_LAT = 3;

  typedef logic [LANE_SELW-1:0] lane_sel_t;

endpackage

// File: rtl/sort_merge_packer.sv
// Packs a serial (index, value) stream into 4-lane groups, padding short groups.
module sort_merge_packer
  import sort_merge_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int WL    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRW-1:0]        in_index,
  input  logic [WL-1:0]           in_value,
  input  logic                    in_last,
  input  logic                    srt_ena,
  output logic                    issue,
  output logic                    grp_last,
  output logic                    held,
  output logic [NLANES-1:0]       lane_valid,
  output logic [NLANES*ADDRW-1:0] lane_index,
  output logic [NLANES*WL-1:0]    lane_value
);

  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] index;
    logic [WL-1:0]    value;
  } lane_t;

  lane_t [NLANES-1:0] pbuf;
  lane_sel_t          cnt;
  logic               grp_full;
  logic               accept;
  logic               close;

  assign issue    = grp_full & srt_ena;
  // A full buffer still accepts when it drains into the sorter this same cycle.
  assign in_ready = !grp_full | srt_ena;
  assign accept   = in_valid & in_ready;
  assign close    = accept & ((cnt == lane_sel_t'(NLANES - 1)) | in_last);
  assign held     = (cnt != '0) | grp_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      grp_full <= 1'b0;
      grp_last <= 1'b0;
      // NOTE: the pack buffer is a handful of flops, so it is reset along with the control state.
      pbuf     <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      if (accept) begin
        if (cnt == '0) begin
          for (int l = 1; l < NLANES; l++) begin
            pbuf[l] <= '{valid: 1'b0, index: '1, value: '0};
          end
        end
        pbuf[cnt] <= '{valid: 1'b1, index: in_index, value: in_value};
        cnt       <= close ? '0 : cnt + lane_sel_t'(1);
      end
      if (close) begin
        grp_full <= 1'b1;
        grp_last <= in_last;
      end else if (issue) begin
        grp_full <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the block can infer a latch.
    lane_valid = '0;
    lane_index = '0;
    lane_value = '0;
    for (int l = 0; l < NLANES; l++) begin
      lane_valid[l]               = pbuf[l].valid & issue;
      lane_index[l*ADDRW +: ADDRW] = pbuf[l].index;
      lane_value[l*WL +: WL]       = pbuf[l].value;
    end
  end

endmodule

// File: rtl/sort_merge4_ctrl.sv
// Sequencing controller around an ena-gated 4-lane sorter: packs, issues, tracks and delivers groups.
module sort_merge4_ctrl
  import sort_merge_pkg::*;
#(
  parameter int ADDRW    = 16,
  parameter int WL       = 32,
  parameter int SORT_LAT = DEF_SORT_LAT,
  parameter int CNTW     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRW-1:0]        in_index,
  input  logic [WL-1:0]           in_value,
  input  logic                    in_last,
  output logic                    srt_ena,
  output logic [NLANES-1:0]       srt_valid,
  output logic [NLANES*ADDRW-1:0] srt_index,
  output logic [NLANES*WL-1:0]    srt_value,
  input  logic [NLANES-1:0]       srt_outvalid,
  input  logic [NLANES*ADDRW-1:0] srt_outindex,
  input  logic [NLANES*WL-1:0]    srt_outvalue,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANES-1:0]       out_vmask,
  output logic [NLANES*ADDRW-1:0] out_index,
  output logic [NLANES*WL-1:0]    out_value,
  output logic                    out_last,
  output logic                    busy,
  output logic [CNTW-1:0]         group_cnt
);

  logic                issue;
  logic                grp_last;
  logic                held;
  logic [SORT_LAT-1:0] tok;
  logic [SORT_LAT-1:0] lastbit;

  // Freezing the whole sorter is the only backpressure path; tokens move in lockstep with it.
  assign srt_ena = !out_valid | out_ready;
  assign busy    = held | (|tok) | out_valid;

  sort_merge_packer #(
    .ADDRW (ADDRW),
    .WL    (WL)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_index   (in_index),
    .in_value   (in_value),
    .in_last    (in_last),
    .srt_ena    (srt_ena),
    .issue      (issue),
    .grp_last   (grp_last),
    .held       (held),
    .lane_valid (srt_valid),
    .lane_index (srt_index),
    .lane_value (srt_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok       <= '0;
      lastbit   <= '0;
      out_valid <= 1'b0;
      out_vmask <= '0;
      out_index <= '0;
      out_value <= '0;
      out_last  <= 1'b0;
      group_cnt <= '0;
    end else begin
      if (srt_ena) begin
        tok     <= (tok << 1) | SORT_LAT'(issue);
        lastbit <= (lastbit << 1) | SORT_LAT'(issue & grp_last);
      end
      // Capture is keyed on tokens alone, so leftover sorter contents after reset are ignored.
      if (srt_ena & tok[SORT_LAT-1]) begin
        out_valid <= 1'b1;
        out_vmask <= srt_outvalid;
        out_index <= srt_outindex;
        out_value <= srt_outvalue;
        out_last  <= lastbit[SORT_LAT-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid & out_ready) begin
        group_cnt <= group_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sort_merge4_ctrl.sv
// Directed bench for sort_merge4_ctrl driving a behavioural 3-stage ena-gated sorter.
module tb_sort_merge4_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic [15:0]  in_index;
  logic [31:0]  in_value;
  logic         srt_ena;
  logic [3:0]   srt_valid, srt_outvalid;
  logic [63:0]  srt_index, srt_outindex;
  logic [127:0] srt_value, srt_outvalue;
  logic         out_valid, out_ready, out_last, busy;
  logic [3:0]   out_vmask;
  logic [63:0]  out_index;
  logic [127:0] out_value;
  logic [15:0]  group_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int put_waits;

  always #5 clk = ~clk;

  sort_merge4_ctrl #(.ADDRW(16), .WL(32), .SORT_LAT(3), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_value(in_value), .in_last(in_last),
    .srt_ena(srt_ena), .srt_valid(srt_valid), .srt_index(srt_index), .srt_value(srt_value),
    .srt_outvalid(srt_outvalid), .srt_outindex(srt_outindex), .srt_outvalue(srt_outvalue),
    .out_valid(out_valid), .out_ready(out_ready), .out_vmask(out_vmask),
    .out_index(out_index), .out_value(out_value), .out_last(out_last),
    .busy(busy), .group_cnt(group_cnt)
  );

  // Behavioural sorter: valid lanes ascending by index, invalid lanes last, 3 ena-gated stages.
  typedef struct packed {
    logic        v;
    logic [15:0] i;
    logic [31:0] d;
  } tl_t;
  typedef tl_t [3:0] grp_t;

  grp_t in_g, st0, st1, st2;

  function automatic grp_t sort_grp(input grp_t a);
    tl_t t;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 3; j++) begin
        if ({~a[j].v, a[j].i} > {~a[j+1].v, a[j+1].i}) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    return a;
  endfunction

  always_comb begin
    in_g = '0;
    srt_outvalid = '0;
    srt_outindex = '0;
    srt_outvalue = '0;
    for (int k = 0; k < 4; k++) begin
      in_g[k].v = srt_valid[k];
      in_g[k].i = srt_index[k*16 +: 16];
      in_g[k].d = srt_value[k*32 +: 32];
      srt_outvalid[k]          = st2[k].v;
      srt_outindex[k*16 +: 16] = st2[k].i;
      srt_outvalue[k*32 +: 32] = st2[k].d;
    end
  end

  always @(posedge clk) begin
    if (srt_ena) begin
      st0 <= sort_grp(in_g);
      st1 <= st0;
      st2 <= st1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one element and returns #1 after the edge that accepted it.
  task automatic put(input logic [15:0] idx, input logic last);
    in_valid  = 1'b1;
    in_index  = idx;
    in_value  = 32'h100 + 32'(idx);
    in_last   = last;
    put_waits = 0;
    while (!in_ready && put_waits < 50) begin
      step();
      put_waits++;
    end
    if (!in_ready) check("put_timeout", {127'b0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, {127'b0, out_valid}, 128'd1);
  endtask

  // Waits for a single-element group, checks it, and lets it be consumed.
  task automatic collect_single(input logic [15:0] idx, input string tag);
    wait_out({tag, "_valid"});
    check({tag, "_index"}, out_index, {48'hffff_ffff_ffff, idx});
    check({tag, "_vmask"}, out_vmask, 128'h1);
    check({tag, "_last"},  out_last,  128'h1);
    step();
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_index = '0; in_value = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_group_cnt", group_cnt, 0);
    check("rst_srt_valid", srt_valid, 0);
    check("rst_out_last", out_last, 0);

    // Two full groups back to back; first output exactly 4 cycles after its 4th accept.
    put(16'd7, 0); put(16'd3, 0); put(16'd9, 0); put(16'd1, 0);
    check("t1_issue", srt_valid, 4'hf);
    put(16'd4, 0); put(16'd2, 0); put(16'd8, 0);
    check("t1_not_yet", out_valid, 0);
    put(16'd6, 1);
    check("t1_g1_valid", out_valid, 1);
    check("t1_g1_index", out_index, 64'h0009_0007_0003_0001);
    check("t1_g1_value", out_value, 128'h00000109_00000107_00000103_00000101);
    check("t1_g1_vmask", out_vmask, 4'hf);
    check("t1_g1_last", out_last, 0);
    repeat (4) step();
    check("t1_g2_valid", out_valid, 1);
    check("t1_g2_index", out_index, 64'h0008_0006_0004_0002);
    check("t1_g2_last", out_last, 1);
    step();
    check("t1_drained", out_valid, 0);
    check("t1_group_cnt", group_cnt, 2);

    // Partial group closed by in_last: padding lanes sort to the top.
    put(16'd5, 0); put(16'd2, 0); put(16'd9, 1);
    repeat (4) step();
    check("t2_valid", out_valid, 1);
    check("t2_index", out_index, 64'hffff_0009_0005_0002);
    check("t2_value", out_value, 128'h00000000_00000109_00000105_00000102);
    check("t2_vmask", out_vmask, 4'b0111);
    check("t2_last", out_last, 1);
    step();
    check("t2_group_cnt", group_cnt, 3);

    // Continuous stream: never stalls, a group issues right after every 4th element.
    for (int i = 0; i < 12; i++) begin
      put(16'(40 - 10 * (i % 4) + i / 4), i == 11);
      check("t3_no_stall", put_waits, 0);
      check("t3_issue", srt_valid, (i % 4 == 3) ? 4'hf : 4'h0);
    end
    repeat (8) step();
    check("t3_idle", busy, 0);
    check("t3_group_cnt", group_cnt, 6);

    // Backpressure with one group at the output and three more behind it.
    put(16'h10, 1); put(16'h11, 1); put(16'h12, 1); put(16'h13, 1);
    wait_out("t4_first");
    out_ready = 1'b0;
    put(16'h14, 1);
    in_valid = 1'b1; in_index = 16'h15; in_value = 32'h115; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_ena", srt_ena, 0);
      check("t4_hold_index", out_index, 64'hffff_ffff_ffff_0010);
      check("t4_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    collect_single(16'h10, "t4_a");
    in_valid = 1'b0; in_last = 1'b0;
    collect_single(16'h11, "t4_b");
    collect_single(16'h12, "t4_c");
    collect_single(16'h13, "t4_d");
    collect_single(16'h14, "t4_e");
    collect_single(16'h15, "t4_f");
    check("t4_group_cnt", group_cnt, 12);

    // Reset with one group in the pipeline and one in the pack buffer.
    put(16'h20, 1); put(16'h21, 1);
    rst_n = 1'b0;
    #2;
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_group_cnt", group_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t5_no_stale", out_valid, 0);
    end
    put(16'h31, 0); put(16'h30, 1);
    wait_out("t5_valid");
    check("t5_index", out_index, 64'hffff_ffff_0031_0030);
    check("t5_value", out_value, 128'h00000000_00000000_00000131_00000130);
    check("t5_vmask", out_vmask, 4'b0011);
    check("t5_last", out_last, 1);
    step();
    check("t5_group_cnt_after", group_cnt, 1);

    // 2^CNTW + 1 single-element groups from a fresh reset wrap the counter to 1.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) put(16'(i), 1);
    begin
      int n = 0;
      while (busy && n < 20) begin
        step();
        n++;
      end
    end
    check("t6_idle", busy, 0);
    check("t6_group_cnt_wrap", group_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
